// File: rtl/mult_div_sequencer_if.sv
// Request/response bundle between the core's control FSM (master) and the
// iterative multiply/divide unit (slave).
interface mult_div_sequencer_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic [CW-1:0]    count;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo, div_by_zero, count
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo, div_by_zero, count
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign correction in a final FIX cycle.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_div_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;     // raw rs, then multiplicand / dividend magnitude
    logic [WIDTH-1:0]   opb_q, opb_d;     // raw rt, then multiplier / divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_neg, rem_neg;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & opa_q[WIDTH-1];
    assign b_neg     = is_signed & opb_q[WIDTH-1];
    assign mag_a     = a_neg ? ('0 - opa_q) : opa_q;
    assign mag_b     = b_neg ? ('0 - opb_q) : opb_q;

    // Multiply step: conditional add into the upper half, then shift {carry, acc} right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: remainder takes the next dividend bit; the difference fits WIDTH when non-negative.
    assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    assign div_ge     = div_rem_sh >= {1'b0, opb_q};
    assign div_diff   = div_rem_sh[WIDTH-1:0] - opb_q;
    assign div_next   = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_neg = '0 - acc_q;
    assign quo_neg  = '0 - acc_q[WIDTH-1:0];
    assign rem_neg  = '0 - acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    opa_d   = bus.rs_val;
                    opb_d   = bus.rt_val;
                    dbz_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                opa_d    = mag_a;
                opb_d    = mag_b;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
                acc_d    = '0;
                count_d  = '0;
                if (is_div && (opb_q == '0)) begin
                    hi_d    = opa_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (is_div) begin
                    acc_d = div_next;
                    opa_d = opa_q << 1;
                end else begin
                    acc_d = mul_next;
                    opb_d = opb_q >> 1;
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div) begin
                    hi_d = neg_hi_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? quo_neg : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed corner cases plus random
// operations against a plain-arithmetic reference model.
module tb_mult_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_sequencer_if #(.WIDTH(W)) bus ();

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic [5:0]  cnt;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed/unsigned 64-bit arithmetic; SV division truncates toward zero.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e, output int lat);
        longint          sa, sb_v, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.dbz = 1'b0;
        e.cnt = 6'd32;
        lat   = 34;
        case (op)
            2'b00: begin p = longint'(sa * sb_v); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = ua * ub;            e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.cnt = 6'd0; lat = 1;
                end else if (op == 2'b10) begin
                    q = sa / sb_v; r = sa % sb_v; e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    q = longint'(ua / ub); r = longint'(ua % ub); e.hi = r[31:0]; e.lo = q[31:0];
                end
            end
        endcase
    endtask

    // Waits for IDLE, pulses start across one edge, and queues the expected result.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   k;
        k = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("idle_timeout", 64'd1, 64'd0);
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        model(op, a, b, e, lat);
        e.due = cyc + lat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hi", bus.hi, mon_e.hi);
                check("lo", bus.lo, mon_e.lo);
                check("div_by_zero", bus.div_by_zero, mon_e.dbz);
                check("count", bus.count, mon_e.cnt);
                check("done_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int bad_busy, bad_hold, bad_done, k;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] specials [5];
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_count", bus.count, 0);
        rst = 1'b0;

        // MULTU 7x6 with busy window, an ignored mid-op start and operand changes.
        issue(2'b01, 32'd7, 32'd6);
        bad_busy = 0; bad_hold = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.busy !== (i <= 34)) bad_busy++;
            if (i < 34 && (bus.hi !== 32'd0 || bus.lo !== 32'd0)) bad_hold++;
            if (i == 9) begin bus.start = 1'b1; bus.rs_val = 32'd99; bus.rt_val = 32'd99; bus.op = 2'b11; end
            if (i == 10) bus.start = 1'b0;
        end
        check("busy_window", bad_busy, 0);
        check("hilo_held_mid_op", bad_hold, 0);
        check("count_after_done", bus.count, 32);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'h0000_1234, 32'd0);
        issue(2'b01, 32'd1, 32'd1);
        check("dbz_cleared_on_start", bus.div_by_zero, 0);

        // Asynchronous reset in the middle of an iteration run.
        issue(2'b01, 32'd5, 32'd5);
        k = 0;
        while (bus.count !== 6'd10 && k < 60) begin @(negedge clk); k++; end
        check("reach_count10", k < 60, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_count", bus.count, 0);
        sb.delete();
        @(negedge clk) rst = 1'b0;
        bad_done = 0;
        repeat (40) begin @(negedge clk); if (bus.done) bad_done++; end
        check("no_done_after_abort", bad_done, 0);
        issue(2'b01, 32'd3, 32'd3);

        // Random operations, back to back, with operands scrambled after acceptance.
        repeat (48) begin
            rop = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = specials[$urandom_range(0, 4)];
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            bus.op     = 2'($urandom_range(0, 3));
        end

        k = 0;
        while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative multiply/divide unit with its own sequencing FSM, serving MULT, MULTU, DIV and DIVU for the multicycle core. The main Control FSM issues a one-cycle `start` with the operation code and the A/B register values. It stalls on `busy` and then reads `hi`/`lo` for the HI/LO write-back and MFHI/MFLO paths. Multiply uses 32-step shift-add; divide uses 32-step restoring division. Both work on operand magnitudes and apply sign correction at the end.

## Interface
- WIDTH, 32, operand width; hi/lo are WIDTH each; iteration count equals WIDTH
- Clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- rs_val  input  WIDTH  multiplicand / dividend (A register)
- rt_val  input  WIDTH  multiplier / divisor (B register)
- busy  output  1  high in LOAD, ITER, FIX
- done  output  1  one-cycle pulse in DONE state
- hi  output  WIDTH  product[63:32] or remainder
- lo  output  WIDTH  product[31:0] or quotient
- div_by_zero  output  1  set on completion of DIV/DIVU with rt_val==0; cleared at next accepted start
- count  output  6  number of iterations completed in the current operation (0..32)

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: if `start`=1, latch op, rs_val, rt_val, clear div_by_zero, and go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - Form magnitudes. For signed ops, a negative operand is negated; |−2^31| = 0x80000000 unsigned.
  - Record result signs: product/quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs). Unsigned ops take sign 0.
  - Clear the accumulator and count.
  - If the op is a divide and rt_val==0, go to DONE directly. Otherwise go to ITER.
- ITER, multiply step: if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator (33-bit add, carry kept). Then shift the {carry, accumulator} right by 1.
- ITER, divide step: shift the {remainder, quotient} pair left 1. Trial-subtract the divisor from the 33-bit remainder. If the result is non-negative, keep it and set quotient LSB = 1. Otherwise restore.
- ITER: each cycle performs one step and increments count. When count reaches 32, go to FIX.
- FIX: negate the product (64-bit), quotient and remainder per the recorded signs. Load hi/lo. Go to DONE.
- DONE: done=1 for one cycle, then return to IDLE. `start` is ignored in DONE.
- Divide by zero: hi = latched rs_val, lo = 0xFFFFFFFF, div_by_zero=1. No iterations run; count stays 0.
- DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. No flag is raised.
- `start` while busy or in DONE is ignored. In-flight operands are unaffected by changes to rs_val/rt_val after acceptance.
- hi/lo hold their value until the next completion. They are not disturbed during an operation.

## Timing
- Reset values: state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, count=0. Reset applies immediately, regardless of clock.
- Reset mid-operation aborts the operation. Outputs return to reset values and no done pulse is produced.
- Let edge 0 be the edge sampling `start`=1 in IDLE:
  - edge 0 enters LOAD
  - edge 1 enters ITER
  - edges 2..33 perform 32 iterations; edge 33 enters FIX
  - edge 34 writes hi/lo and enters DONE
  - done is high between edge 34 and edge 35
  - edge 35 returns to IDLE
- Latency from start edge to done asserted: 34 cycles.
- Divide-by-zero path: edge 1 enters DONE with hi/lo/div_by_zero written; done is high between edges 1 and 2.
- busy is high from after edge 0 through edge 34.
- Minimum start-to-start spacing is 36 cycles; a new start is accepted at edge 36 at the earliest.

## Test plan
- MULTU 7×6 with start at edge 0 -> busy high edges 1..34, done pulse after edge 34, hi=0x00000000, lo=0x0000002A, count=32.
- MULT 0xFFFFFFFD (−3) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 ÷ 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 ÷ 7 -> lo=14, hi=2. DIV 0x80000000 ÷ 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 ÷ 0 -> done after edge 1, hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1. The next accepted start clears div_by_zero.
- start pulse at edge 10 of a running op, plus rs_val/rt_val changed mid-op -> ignored; the original result is produced at edge 34 and hi/lo are unchanged before then.
- reset asserted while count=10 -> busy=0, done=0, hi=lo=0 immediately, no done pulse. A new MULTU 3×3 then completes normally with lo=9.
